// File: rtl/vc_test_scoreboard.sv
// vc_test_scoreboard
// ------------------
// Multi-channel streaming checker for unit-test harnesses. Each channel
// holds a FIFO of expected messages, and each message has its own
// don't-care mask. Actual messages from the DUT arrive on a val/rdy port.
// Each one is compared against the head of its channel's queue. The block
// keeps saturating pass/fail counters, captures the first mismatch, and
// ends a test either when every queue has drained or when the DUT stays
// silent for too long during the drain phase.
//
// Ports
//   clk        : clock, all state updates on posedge
//   reset_n    : asynchronous active-low reset
//   go         : start/restart pulse, honoured in IDLE or DONE
//   end_req    : no more expected messages will follow (honoured in RUN)
//   exp_val/exp_rdy/exp_msg/exp_mask : per-channel expected-message input
//   act_val/act_rdy/act_msg          : per-channel actual-message input
//   busy       : RUN or DRAIN
//   done       : DONE
//   timed_out  : DONE was reached because the drain phase went idle too long
//   num_pass/num_fail : saturating comparison counters
//   fail_valid/fail_chan/fail_idx/fail_exp/fail_act : first mismatch record

module vc_test_scoreboard #(
    parameter int p_nchan   = 2,
    parameter int p_nbits   = 32,
    parameter int p_depth   = 16,
    parameter int p_cntbits = 16,
    parameter int p_timeout = 1024
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         go,
    input  logic                         end_req,
    input  logic [p_nchan-1:0]           exp_val,
    output logic [p_nchan-1:0]           exp_rdy,
    input  logic [p_nchan*p_nbits-1:0]   exp_msg,
    input  logic [p_nchan*p_nbits-1:0]   exp_mask,
    input  logic [p_nchan-1:0]           act_val,
    output logic [p_nchan-1:0]           act_rdy,
    input  logic [p_nchan*p_nbits-1:0]   act_msg,
    output logic                         busy,
    output logic                         done,
    output logic                         timed_out,
    output logic [p_cntbits-1:0]         num_pass,
    output logic [p_cntbits-1:0]         num_fail,
    output logic                         fail_valid,
    output logic [2:0]                   fail_chan,
    output logic [p_cntbits-1:0]         fail_idx,
    output logic [p_nbits-1:0]           fail_exp,
    output logic [p_nbits-1:0]           fail_act
);

    localparam int AW = $clog2(p_depth);
    localparam int PW = AW + 1;
    localparam int TW = $clog2(p_timeout + 1);
    localparam int SW = $clog2(p_nchan + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Queue storage and pointers. The pointers carry one extra bit so that
    // full and empty can be told apart when the low bits are equal.
    logic [p_nbits-1:0]   q_msg  [p_nchan][p_depth];
    logic [p_nbits-1:0]   q_mask [p_nchan][p_depth];
    logic [PW-1:0]        wr_ptr [p_nchan];
    logic [PW-1:0]        rd_ptr [p_nchan];
    logic [p_cntbits-1:0] idx    [p_nchan];

    logic [p_nbits-1:0]   head_msg  [p_nchan];
    logic [p_nbits-1:0]   head_mask [p_nchan];
    logic [p_nbits-1:0]   act_ch    [p_nchan];

    logic [p_nchan-1:0]   full;
    logic [p_nchan-1:0]   empty;
    logic [p_nchan-1:0]   enq;
    logic [p_nchan-1:0]   deq;
    logic [p_nchan-1:0]   pass_vec;
    logic [p_nchan-1:0]   fail_vec;

    logic [SW-1:0]        pass_cnt;
    logic [SW-1:0]        fail_cnt;
    logic [2:0]           sel_chan;
    logic [p_cntbits-1:0] sel_idx;
    logic [p_nbits-1:0]   sel_exp;
    logic [p_nbits-1:0]   sel_act;

    logic [TW-1:0]        idle_cnt;
    logic [TW-1:0]        idle_inc;
    logic                 flush;
    logic                 timeout_hit;

    function automatic logic [p_cntbits-1:0] sat_add(
        input logic [p_cntbits-1:0] a,
        input logic [SW-1:0]        b
    );
        logic [p_cntbits:0] s;
        s = {1'b0, a} + (p_cntbits + 1)'(b);
        return s[p_cntbits] ? '1 : s[p_cntbits-1:0];
    endfunction

    assign busy     = (state == RUN) || (state == DRAIN);
    assign done     = (state == DONE);
    assign idle_inc = idle_cnt + TW'(1);

    // Per-channel queue status, handshakes and masked comparison. Neither
    // ready bypasses: a full queue refuses data even while it dequeues,
    // and a freshly written entry is not visible until the next cycle.
    always_comb begin
        empty    = '0;
        full     = '0;
        exp_rdy  = '0;
        act_rdy  = '0;
        enq      = '0;
        deq      = '0;
        pass_vec = '0;
        fail_vec = '0;
        for (int c = 0; c < p_nchan; c++) begin
            empty[c]     = (wr_ptr[c] == rd_ptr[c]);
            full[c]      = (wr_ptr[c][AW] != rd_ptr[c][AW]) &&
                           (wr_ptr[c][AW-1:0] == rd_ptr[c][AW-1:0]);
            head_msg[c]  = q_msg[c][rd_ptr[c][AW-1:0]];
            head_mask[c] = q_mask[c][rd_ptr[c][AW-1:0]];
            act_ch[c]    = act_msg[c*p_nbits +: p_nbits];
            exp_rdy[c]   = (state == RUN) && !full[c];
            act_rdy[c]   = ((state == RUN) || (state == DRAIN)) && !empty[c];
            enq[c]       = exp_val[c] && exp_rdy[c];
            deq[c]       = act_val[c] && act_rdy[c];
            if (((act_ch[c] ^ head_msg[c]) & ~head_mask[c]) == '0)
                pass_vec[c] = deq[c];
            else
                fail_vec[c] = deq[c];
        end
    end

    // Tally this cycle's results and pick the failing channel to record.
    // The loop walks downward so that the lowest failing channel is the
    // last one assigned and therefore wins.
    always_comb begin
        pass_cnt = '0;
        fail_cnt = '0;
        sel_chan = '0;
        sel_idx  = '0;
        sel_exp  = '0;
        sel_act  = '0;
        for (int c = p_nchan - 1; c >= 0; c--) begin
            if (pass_vec[c])
                pass_cnt = pass_cnt + SW'(1);
            if (fail_vec[c]) begin
                fail_cnt = fail_cnt + SW'(1);
                sel_chan = 3'(c);
                sel_idx  = idx[c];
                sel_exp  = head_msg[c];
                sel_act  = act_ch[c];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Draining ends as soon as every queue is empty. Otherwise the drain
    // times out on the edge at which the idle count reaches p_timeout, so
    // DRAIN lasts exactly p_timeout silent cycles.
    always_comb begin
        state_next  = state;
        flush       = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    state_next = RUN;
                    flush      = 1'b1;
                end
            end
            RUN: begin
                if (end_req)
                    state_next = DRAIN;
            end
            DRAIN: begin
                if (&empty) begin
                    state_next = DONE;
                end else if (!(|deq) && (idle_inc == TW'(p_timeout))) begin
                    state_next  = DONE;
                    timeout_hit = 1'b1;
                end
            end
            DONE: begin
                if (go) begin
                    state_next = RUN;
                    flush      = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < p_nchan; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                idx[c]    <= '0;
            end
            num_pass   <= '0;
            num_fail   <= '0;
            fail_valid <= 1'b0;
            fail_chan  <= '0;
            fail_idx   <= '0;
            fail_exp   <= '0;
            fail_act   <= '0;
            timed_out  <= 1'b0;
            idle_cnt   <= '0;
        end else if (flush) begin
            for (int c = 0; c < p_nchan; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                idx[c]    <= '0;
            end
            num_pass   <= '0;
            num_fail   <= '0;
            fail_valid <= 1'b0;
            fail_chan  <= '0;
            fail_idx   <= '0;
            fail_exp   <= '0;
            fail_act   <= '0;
            timed_out  <= 1'b0;
            idle_cnt   <= '0;
        end else begin
            for (int c = 0; c < p_nchan; c++) begin
                if (enq[c])
                    wr_ptr[c] <= wr_ptr[c] + PW'(1);
                if (deq[c]) begin
                    rd_ptr[c] <= rd_ptr[c] + PW'(1);
                    idx[c]    <= idx[c] + p_cntbits'(1);
                end
            end
            num_pass <= sat_add(num_pass, pass_cnt);
            num_fail <= sat_add(num_fail, fail_cnt);
            if (!fail_valid && (|fail_vec)) begin
                fail_valid <= 1'b1;
                fail_chan  <= sel_chan;
                fail_idx   <= sel_idx;
                fail_exp   <= sel_exp;
                fail_act   <= sel_act;
            end
            if (timeout_hit)
                timed_out <= 1'b1;
            if ((state == DRAIN) && !(|deq))
                idle_cnt <= idle_inc;
            else
                idle_cnt <= '0;
        end
    end

    // Queue payload RAM. It has no reset because only the pointers decide
    // which entries are live.
    always_ff @(posedge clk) begin
        for (int c = 0; c < p_nchan; c++) begin
            if (enq[c]) begin
                q_msg[c][wr_ptr[c][AW-1:0]]  <= exp_msg[c*p_nbits +: p_nbits];
                q_mask[c][wr_ptr[c][AW-1:0]] <= exp_mask[c*p_nbits +: p_nbits];
            end
        end
    end

endmodule

// File: tb/tb_vc_test_scoreboard.sv
// tb_vc_test_scoreboard
// ---------------------
// Directed bench for vc_test_scoreboard with two 32-bit channels, 16-deep
// queues and an 8-cycle drain timeout. Every expected value is a
// hand-computed constant.

module tb_vc_test_scoreboard;

    localparam int NCH = 2;
    localparam int NB  = 32;
    localparam int CB  = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              go;
    logic              end_req;
    logic [NCH-1:0]    exp_val;
    logic [NCH-1:0]    exp_rdy;
    logic [NCH*NB-1:0] exp_msg;
    logic [NCH*NB-1:0] exp_mask;
    logic [NCH-1:0]    act_val;
    logic [NCH-1:0]    act_rdy;
    logic [NCH*NB-1:0] act_msg;
    logic              busy;
    logic              done;
    logic              timed_out;
    logic [CB-1:0]     num_pass;
    logic [CB-1:0]     num_fail;
    logic              fail_valid;
    logic [2:0]        fail_chan;
    logic [CB-1:0]     fail_idx;
    logic [NB-1:0]     fail_exp;
    logic [NB-1:0]     fail_act;

    int checks   = 0;
    int failures = 0;

    vc_test_scoreboard #(
        .p_nchan   (NCH),
        .p_nbits   (NB),
        .p_depth   (16),
        .p_cntbits (CB),
        .p_timeout (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .go         (go),
        .end_req    (end_req),
        .exp_val    (exp_val),
        .exp_rdy    (exp_rdy),
        .exp_msg    (exp_msg),
        .exp_mask   (exp_mask),
        .act_val    (act_val),
        .act_rdy    (act_rdy),
        .act_msg    (act_msg),
        .busy       (busy),
        .done       (done),
        .timed_out  (timed_out),
        .num_pass   (num_pass),
        .num_fail   (num_fail),
        .fail_valid (fail_valid),
        .fail_chan  (fail_chan),
        .fail_idx   (fail_idx),
        .fail_exp   (fail_exp),
        .fail_act   (fail_act)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, want);
        end
    endtask

    // Drive one cycle of inputs, let one rising edge sample them, then
    // return 1 ns after that edge with all inputs back at zero.
    task automatic applyStimulus(
        input logic        g,
        input logic        e,
        input logic [1:0]  ev,
        input logic [31:0] m0,
        input logic [31:0] k0,
        input logic [31:0] m1,
        input logic [31:0] k1,
        input logic [1:0]  av,
        input logic [31:0] a0,
        input logic [31:0] a1
    );
        go       = g;
        end_req  = e;
        exp_val  = ev;
        exp_msg  = {m1, m0};
        exp_mask = {k1, k0};
        act_val  = av;
        act_msg  = {a1, a0};
        @(posedge clk);
        #1;
        go       = 1'b0;
        end_req  = 1'b0;
        exp_val  = '0;
        exp_msg  = '0;
        exp_mask = '0;
        act_val  = '0;
        act_msg  = '0;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
    endtask

    task automatic goPulse();
        applyStimulus(1'b1, 1'b0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
    endtask

    task automatic endPulse();
        applyStimulus(1'b0, 1'b1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
    endtask

    initial begin
        reset_n  = 1'b0;
        go       = 1'b0;
        end_req  = 1'b0;
        exp_val  = '0;
        exp_msg  = '0;
        exp_mask = '0;
        act_val  = '0;
        act_msg  = '0;
        #12;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_exp_rdy", exp_rdy, 0);
        checkOutput("rst_act_rdy", act_rdy, 0);
        checkOutput("rst_num_pass", num_pass, 0);
        checkOutput("rst_fail_valid", fail_valid, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("idle_busy", busy, 0);

        // Test 1: channel 0 all passing, then a normal drain.
        goPulse();
        checkOutput("t1_busy", busy, 1);
        checkOutput("t1_exp_rdy", exp_rdy, 2'b11);
        applyStimulus(1'b0, 1'b0, 2'b01, 3, 0, 0, 0, 2'b00, 0, 0);
        applyStimulus(1'b0, 1'b0, 2'b01, 5, 0, 0, 0, 2'b00, 0, 0);
        applyStimulus(1'b0, 1'b0, 2'b01, 7, 0, 0, 0, 2'b00, 0, 0);
        checkOutput("t1_act_rdy", act_rdy, 2'b01);
        applyStimulus(1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 2'b01, 3, 0);
        applyStimulus(1'b0, 1'b1, 2'b00, 0, 0, 0, 0, 2'b01, 5, 0);
        checkOutput("t1_drain_exp_rdy", exp_rdy, 2'b00);
        applyStimulus(1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 2'b01, 7, 0);
        checkOutput("t1_not_done_yet", done, 0);
        checkOutput("t1_num_pass", num_pass, 3);
        idleCycle();
        checkOutput("t1_done", done, 1);
        checkOutput("t1_timed_out", timed_out, 0);
        checkOutput("t1_num_fail", num_fail, 0);
        checkOutput("t1_busy_off", busy, 0);

        // Test 2: masked compare on channel 1, one pass then one fail.
        goPulse();
        checkOutput("t2_cleared_pass", num_pass, 0);
        applyStimulus(1'b0, 1'b0, 2'b10, 0, 0, 32'h0000_00AA, 32'h0000_000F, 2'b00, 0, 0);
        applyStimulus(1'b0, 1'b0, 2'b10, 0, 0, 32'h0000_00AA, 32'h0000_000F, 2'b00, 0, 0);
        applyStimulus(1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 2'b10, 0, 32'h0000_00A5);
        checkOutput("t2_pass_after_first", num_pass, 1);
        checkOutput("t2_no_fail_yet", fail_valid, 0);
        applyStimulus(1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 2'b10, 0, 32'h0000_01A0);
        checkOutput("t2_num_pass", num_pass, 1);
        checkOutput("t2_num_fail", num_fail, 1);
        checkOutput("t2_fail_valid", fail_valid, 1);
        checkOutput("t2_fail_chan", fail_chan, 1);
        checkOutput("t2_fail_idx", fail_idx, 1);
        checkOutput("t2_fail_exp", fail_exp, 32'h0000_00AA);
        checkOutput("t2_fail_act", fail_act, 32'h0000_01A0);
        endPulse();
        idleCycle();
        checkOutput("t2_done", done, 1);
        checkOutput("t2_held_fail_act", fail_act, 32'h0000_01A0);

        // Test 3: fill channel 0, then a blocked enqueue on a dequeue cycle.
        goPulse();
        checkOutput("t3_fail_cleared", fail_valid, 0);
        for (int i = 0; i < 16; i++)
            applyStimulus(1'b0, 1'b0, 2'b01, i, 0, 0, 0, 2'b00, 0, 0);
        checkOutput("t3_full_rdy", exp_rdy, 2'b10);
        applyStimulus(1'b0, 1'b0, 2'b01, 100, 0, 0, 0, 2'b01, 0, 0);
        checkOutput("t3_rdy_back", exp_rdy, 2'b11);
        checkOutput("t3_pass1", num_pass, 1);
        for (int i = 1; i < 16; i++)
            applyStimulus(1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 2'b01, i, 0);
        checkOutput("t3_empty_after_drain", act_rdy, 2'b00);
        checkOutput("t3_pass16", num_pass, 16);
        checkOutput("t3_fail0", num_fail, 0);
        endPulse();
        idleCycle();
        checkOutput("t3_done", done, 1);

        // Test 4: both channels fail together, then channel 0 fails again.
        goPulse();
        applyStimulus(1'b0, 1'b0, 2'b11, 32'h10, 0, 32'h20, 0, 2'b00, 0, 0);
        applyStimulus(1'b0, 1'b0, 2'b01, 32'h11, 0, 0, 0, 2'b00, 0, 0);
        applyStimulus(1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 2'b11, 32'hFF, 32'hEE);
        checkOutput("t4_fail_two", num_fail, 2);
        checkOutput("t4_fail_chan", fail_chan, 0);
        checkOutput("t4_fail_exp", fail_exp, 32'h10);
        checkOutput("t4_fail_act", fail_act, 32'hFF);
        applyStimulus(1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 2'b01, 32'h12, 0);
        checkOutput("t4_fail_three", num_fail, 3);
        checkOutput("t4_fail_chan_held", fail_chan, 0);
        checkOutput("t4_fail_idx_held", fail_idx, 0);
        checkOutput("t4_fail_act_held", fail_act, 32'hFF);
        checkOutput("t4_pass0", num_pass, 0);

        // Test 5: go ignored in RUN, then drain timeout.
        goPulse();
        checkOutput("t5_go_ignored", num_fail, 3);
        endPulse();
        idleCycle();
        checkOutput("t5_empty_done", done, 1);
        goPulse();
        applyStimulus(1'b0, 1'b0, 2'b01, 1, 0, 0, 0, 2'b00, 0, 0);
        applyStimulus(1'b0, 1'b0, 2'b01, 2, 0, 0, 0, 2'b00, 0, 0);
        endPulse();
        for (int i = 0; i < 7; i++)
            idleCycle();
        checkOutput("t5_still_drain", busy, 1);
        checkOutput("t5_not_done_7", done, 0);
        idleCycle();
        checkOutput("t5_done_8", done, 1);
        checkOutput("t5_timed_out", timed_out, 1);
        goPulse();
        checkOutput("t5_run_busy", busy, 1);
        checkOutput("t5_q_empty", act_rdy, 2'b00);
        checkOutput("t5_exp_rdy", exp_rdy, 2'b11);
        checkOutput("t5_pass_clr", num_pass, 0);
        checkOutput("t5_fail_clr", num_fail, 0);
        checkOutput("t5_to_clr", timed_out, 0);
        checkOutput("t5_fv_clr", fail_valid, 0);

        // Test 6: asynchronous reset in the middle of a run.
        for (int i = 1; i <= 4; i++)
            applyStimulus(1'b0, 1'b0, 2'b01, i, 0, 0, 0, 2'b00, 0, 0);
        applyStimulus(1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 2'b01, 1, 0);
        applyStimulus(1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 2'b01, 2, 0);
        checkOutput("t6_pass2", num_pass, 2);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("t6_rst_busy", busy, 0);
        checkOutput("t6_rst_pass", num_pass, 0);
        checkOutput("t6_rst_act_rdy", act_rdy, 2'b00);
        checkOutput("t6_rst_exp_rdy", exp_rdy, 2'b00);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        goPulse();
        checkOutput("t6_post_empty", act_rdy, 2'b00);
        applyStimulus(1'b0, 1'b0, 2'b01, 9, 0, 0, 0, 2'b00, 0, 0);
        applyStimulus(1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 2'b01, 9, 0);
        checkOutput("t6_post_pass", num_pass, 1);
        endPulse();
        idleCycle();
        checkOutput("t6_post_done", done, 1);
        checkOutput("t6_post_to", timed_out, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vc_test_scoreboard.md
Name: vc_test_scoreboard

Overview:
- Parametrised, multi-channel, synthesizable checker for unit-test harnesses.
- Each channel queues expected messages, each with a don't-care mask, and compares them in order against actual messages arriving on a val/rdy interface.
- Keeps pass/fail counts, captures the first mismatch, and detects drain timeout.
- Sits in the tester module between the DUT output ports and the test-suite control.
- Replaces per-net directed checks with streaming, cycle-accurate checking.

Parameters:
- p_nchan, 2, number of independent checked channels (1..8)
- p_nbits, 32, message width per channel
- p_depth, 16, expected-queue entries per channel (power of two, >=2)
- p_cntbits, 16, width of pass/fail counters
- p_timeout, 1024, idle cycles allowed in DRAIN before timing out (>=1)

Ports:
- clk  in  1  clock; all state updates on posedge
- reset_n  in  1  asynchronous active-low reset
- go  in  1  start/restart pulse
- end_req  in  1  no more expected messages will be supplied
- exp_val  in  p_nchan  expected-message valid, per channel
- exp_rdy  out  p_nchan  expected queue not full, per channel
- exp_msg  in  p_nchan*p_nbits  expected messages; channel c occupies bits [c*p_nbits +: p_nbits]
- exp_mask  in  p_nchan*p_nbits  per-bit don't-care (1 = ignore bit), stored with exp_msg
- act_val  in  p_nchan  actual-message valid, per channel
- act_rdy  out  p_nchan  actual accepted, per channel
- act_msg  in  p_nchan*p_nbits  actual messages from the DUT
- busy  out  1  state is RUN or DRAIN
- done  out  1  state is DONE
- timed_out  out  1  DONE was reached by timeout
- num_pass  out  p_cntbits  passing comparisons
- num_fail  out  p_cntbits  failing comparisons
- fail_valid  out  1  a first mismatch has been captured
- fail_chan  out  3  channel of the first mismatch
- fail_idx  out  p_cntbits  per-channel message index of the first mismatch (0-based)
- fail_exp  out  p_nbits  expected value of the first mismatch, unmasked
- fail_act  out  p_nbits  actual value of the first mismatch

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; all queues empty; all counters and capture registers 0; all outputs 0.
  - Effective mid-test: a pending comparison is discarded.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE --go--> RUN.
  - RUN --end_req--> DRAIN.
  - DRAIN --(all queues empty)--> DONE.
  - DRAIN --(idle count == p_timeout)--> DONE with timed_out=1.
  - DONE --go--> RUN.
  - go in RUN or DRAIN is ignored. end_req outside RUN is ignored.
- go accepted in IDLE or DONE: flushes all queues and clears num_pass, num_fail, the fail_* registers, timed_out and the per-channel indices, in the same edge.
- exp_rdy[c] = (state==RUN) && !full[c].
  - No full-bypass: a full queue is not ready even if it dequeues in the same cycle.
  - Enqueue fires when exp_val[c] && exp_rdy[c].
- act_rdy[c] = (state is RUN or DRAIN) && !empty[c].
  - No empty-bypass: an expected entry enqueued at edge N is comparable from cycle N+1.
- Comparison, on an actual handshake:
  - pass iff ((act ^ exp) & ~mask) == 0; the head entry dequeues.
  - Results are registered: counters change on the edge that completes the handshake.
  - The per-channel index increments on every handshake.
- Counters: each edge adds the number of channels that passed (or failed) that cycle, so multiple channels can add in one cycle. Both counters saturate at all-ones.
- First-fail capture:
  - Loads only while fail_valid=0.
  - If several channels fail in the same cycle, the lowest channel number wins.
- Queue pointers: width log2(p_depth)+1; wrap modulo 2*p_depth; full/empty are distinguished by the MSB.
- Idle counter: runs only in DRAIN; clears on any actual handshake; increments otherwise.
- done, timed_out and the fail_* registers are held in DONE until go or reset.

Test Plan:
- Ch0: enqueue 3, 5, 7 with mask 0; DUT sends 3, 5, 7 at one per cycle; end_req -> num_pass=3, num_fail=0, done=1 one edge after the last dequeue, timed_out=0.
- Ch1: expect 32'h0000_00AA with mask 32'h0000_000F; DUT sends 32'h0000_00A5 (pass), then 32'h0000_01A0 (fail) -> num_pass=1, num_fail=1, fail_chan=1, fail_idx=1, fail_exp=32'h0000_00AA, fail_act=32'h0000_01A0.
- Fill ch0 with 16 entries while act_val=0 -> exp_rdy[0]=0 after the 16th enqueue. Raise act_val and exp_val in the same cycle -> the dequeue completes and the enqueue does not; exp_rdy[0]=1 the next cycle.
- Both channels fail in the same cycle on the first message, then ch0 fails again -> num_fail=3 (increments by 2 on the first edge), fail_chan=0, fail_idx=0.
- p_timeout=8: 2 entries queued in ch0, end_req, DUT silent -> done=1 and timed_out=1 exactly 8 DRAIN cycles after entering DRAIN; a following go -> queues empty, counters 0, state RUN.
- Assert reset_n=0 mid-RUN with 4 queued entries and num_pass=2 -> all outputs 0 immediately (async), state IDLE; go after release -> normal run.
